// File: rtl/input_debouncer.sv
// Consecutive-sample debouncer: clean level, rise/fall pulses and a sticky event flag.
// Define DEBOUNCER_SYNC_FRONTEND_EN to add a 2-flop synchronizer on signal_i (+2 cycles latency).
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic        RESET_LEVEL     = 1'b0,
    parameter int unsigned CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic signal_i,
    input  logic clear_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_o
);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
            $error("input_debouncer: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sample;
    logic                 differs;

`ifdef DEBOUNCER_SYNC_FRONTEND_EN
    // Both stages reset to the idle level so release from reset never looks like a change.
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {2{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[0], signal_i};
        end
    end

    assign sample = sync_q[1];
`else
    assign sample = signal_i;
`endif

    assign differs = (sample != level_o);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= STABLE;
            cnt     <= '0;
            level_o <= RESET_LEVEL;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
            event_o <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (clear_i) begin
                event_o <= 1'b0;
            end
            case (state)
                STABLE: begin
                    cnt <= '0;
                    if (differs) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!differs) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Accept; the event set is written after the clear so it wins.
                        level_o <= sample;
                        rise_o  <= sample;
                        fall_o  <= ~sample;
                        event_o <= 1'b1;
                        state   <= STABLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
